// File: rtl/spi_slave_fullduplex.sv
// Full-duplex SPI mode-0 slave, MSB first, with a one-entry transmit buffer.
// Optional macro SPI_SLV_MISO_TRISTATE_EN adds a miso_oe output for shared-miso buses.
module spi_slave_fullduplex #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              underrun
`ifdef SPI_SLV_MISO_TRISTATE_EN
    ,
    output logic              miso_oe
`endif
);

    localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic {StIdle, StActive} state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
    logic                    sclk_prev_q, sclk_prev_d;
    logic                    cs_prev_q, cs_prev_d;
    logic                    sclk_rise_q, sclk_rise_d;
    logic                    sclk_fall_q, sclk_fall_d;
    logic                    cs_rise_q, cs_rise_d;
    logic                    cs_fall_q, cs_fall_d;
    logic [CntW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                    reload_q, reload_d;
    logic [DATA_W-1:0]       rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]       rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0]       tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]       buf_q, buf_d;
    logic                    buf_full_q, buf_full_d;
    logic                    underrun_q, underrun_d;

    logic sclk_s, cs_s, mosi_s;
    logic byte_load;
    logic tx_accept;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Synchronizers and registered edge strobes; sclk edges are masked while deselected.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        sclk_rise_d = sclk_s & ~sclk_prev_q & ~cs_s;
        sclk_fall_d = ~sclk_s & sclk_prev_q & ~cs_s;
        cs_rise_d   = cs_s & ~cs_prev_q;
        cs_fall_d   = ~cs_s & cs_prev_q;
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        reload_d   = reload_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_shift_d = tx_shift_q;
        byte_load  = 1'b0;

        case (state_q)
            StIdle: begin
                if (cs_fall_q) begin
                    state_d   = StActive;
                    bit_cnt_d = '0;
                    byte_load = 1'b1;
                end
            end
            StActive: begin
                if (cs_rise_q) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    reload_d  = 1'b0;
                end else if (sclk_rise_q) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                    if (bit_cnt_q == CntW'(DATA_W - 1)) begin
                        rx_data_d  = {rx_shift_q[DATA_W-2:0], mosi_s};
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        reload_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall_q) begin
                    if (reload_q) begin
                        byte_load = 1'b1;
                        reload_d  = 1'b0;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (byte_load) begin
            tx_shift_d = buf_full_q ? buf_q : '0;
        end
    end

    // A byte load frees the buffer in the same cycle, so a coincident write is accepted.
    always_comb begin
        tx_accept  = tx_load & (~buf_full_q | byte_load);
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        underrun_d = underrun_q;
        if (byte_load) begin
            buf_full_d = 1'b0;
        end
        if (tx_accept) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
            underrun_d = 1'b0;
        end
        if (byte_load && !buf_full_q) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            sclk_sync_q <= '1;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b1;
            cs_prev_q   <= 1'b1;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            bit_cnt_q   <= '0;
            reload_q    <= 1'b0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            cs_rise_q   <= cs_rise_d;
            cs_fall_q   <= cs_fall_d;
            bit_cnt_q   <= bit_cnt_d;
            reload_q    <= reload_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            underrun_q  <= underrun_d;
        end
    end

    assign miso     = (state_q == StActive) ? tx_shift_q[DATA_W-1] : 1'b0;
    assign tx_ready = ~buf_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q == StActive);
    assign underrun = underrun_q;
`ifdef SPI_SLV_MISO_TRISTATE_EN
    assign miso_oe  = (state_q == StActive);
`endif

endmodule

// File: tb/tb_spi_slave_fullduplex.sv
// Directed bench for spi_slave_fullduplex: a mode-0 master model driven on clk negedges.
module tb_spi_slave_fullduplex;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       underrun;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         rx_cnt = 0;
    int         c0;
    logic [7:0] rx_last = 8'h00;
    logic [7:0] rx_prev = 8'h00;
    logic [15:0] got;
    bit         loaded;

    spi_slave_fullduplex #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_cnt  = rx_cnt + 1;
            rx_prev = rx_last;
            rx_last = rx_data;
        end
    end

    // Master: 8-clk sclk period; miso sampled just before each rising edge.
    task automatic spi_bits(input logic [15:0] data, input int nbits, input bit raise_cs,
                            output logic [15:0] rcv);
        rcv = '0;
        @(negedge clk);
        cs   = 1'b0;
        mosi = data[15];
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rcv[15-i] = miso;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            if (i + 1 < nbits) mosi = data[14-i];
            repeat (4) @(negedge clk);
        end
        if (raise_cs) begin
            cs = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic load_byte(input logic [7:0] b);
        @(negedge clk);
        tx_data = b;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total_cnt++; if (miso !== 1'b0) $display("FAIL reset_miso got %b exp 0", miso); else pass_cnt++;
        total_cnt++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready got %b exp 1", tx_ready); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h exp 00", rx_data); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b exp 0", rx_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (underrun !== 1'b0) $display("FAIL reset_underrun got %b exp 0", underrun); else pass_cnt++;
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_underrun;
        c0 = rx_cnt;
        spi_bits({8'h5A, 8'h00}, 8, 1'b1, got);
        total_cnt++; if (got[15:8] !== 8'h00) $display("FAIL underrun_miso got %h exp 00", got[15:8]); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h5A) $display("FAIL underrun_rx_data got %h exp 5a", rx_data); else pass_cnt++;
        total_cnt++; if (rx_cnt !== c0 + 1) $display("FAIL underrun_rx_pulses got %0d exp %0d", rx_cnt - c0, 1); else pass_cnt++;
        total_cnt++; if (underrun !== 1'b1) $display("FAIL underrun_set got %b exp 1", underrun); else pass_cnt++;
        load_byte(8'h99);
        total_cnt++; if (underrun !== 1'b0) $display("FAIL underrun_clear got %b exp 0", underrun); else pass_cnt++;
        total_cnt++; if (tx_ready !== 1'b0) $display("FAIL underrun_ready got %b exp 0", tx_ready); else pass_cnt++;
    endtask

    task automatic test_partial;
        c0 = rx_cnt;
        spi_bits({8'hFF, 8'h00}, 5, 1'b1, got);
        total_cnt++; if (got[15:11] !== 5'b10011) $display("FAIL partial_miso got %b exp 10011", got[15:11]); else pass_cnt++;
        total_cnt++; if (rx_cnt !== c0) $display("FAIL partial_no_valid got %0d exp 0", rx_cnt - c0); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h5A) $display("FAIL partial_rx_hold got %h exp 5a", rx_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL partial_busy got %b exp 0", busy); else pass_cnt++;
        spi_bits({8'hC3, 8'h00}, 8, 1'b1, got);
        total_cnt++; if (rx_data !== 8'hC3) $display("FAIL partial_next_rx got %h exp c3", rx_data); else pass_cnt++;
        total_cnt++; if (rx_cnt !== c0 + 1) $display("FAIL partial_next_pulses got %0d exp 1", rx_cnt - c0); else pass_cnt++;
    endtask

    task automatic test_single;
        c0 = rx_cnt;
        load_byte(8'hA5);
        total_cnt++; if (tx_ready !== 1'b0) $display("FAIL single_ready_low got %b exp 0", tx_ready); else pass_cnt++;
        spi_bits({8'h3C, 8'h00}, 8, 1'b1, got);
        total_cnt++; if (got[15:8] !== 8'hA5) $display("FAIL single_miso got %h exp a5", got[15:8]); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h3C) $display("FAIL single_rx_data got %h exp 3c", rx_data); else pass_cnt++;
        total_cnt++; if (rx_cnt !== c0 + 1) $display("FAIL single_pulses got %0d exp 1", rx_cnt - c0); else pass_cnt++;
        total_cnt++; if (tx_ready !== 1'b1) $display("FAIL single_ready_high got %b exp 1", tx_ready); else pass_cnt++;
    endtask

    task automatic reload_when_ready;
        loaded = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) begin
                tx_data = 8'h7E;
                tx_load = 1'b1;
                @(negedge clk);
                tx_load = 1'b0;
                loaded = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_back_to_back;
        c0 = rx_cnt;
        load_byte(8'h81);
        fork
            spi_bits({8'h12, 8'h34}, 16, 1'b1, got);
            reload_when_ready();
        join
        total_cnt++; if (loaded !== 1'b1) $display("FAIL b2b_reload_timeout got %b exp 1", loaded); else pass_cnt++;
        total_cnt++; if (got !== 16'h817E) $display("FAIL b2b_miso got %h exp 817e", got); else pass_cnt++;
        total_cnt++; if (rx_cnt !== c0 + 2) $display("FAIL b2b_pulses got %0d exp 2", rx_cnt - c0); else pass_cnt++;
        total_cnt++; if (rx_prev !== 8'h12) $display("FAIL b2b_rx_first got %h exp 12", rx_prev); else pass_cnt++;
        total_cnt++; if (rx_last !== 8'h34) $display("FAIL b2b_rx_second got %h exp 34", rx_last); else pass_cnt++;
    endtask

    task automatic test_ignored_load;
        load_byte(8'h0F);
        load_byte(8'hFF);
        total_cnt++; if (tx_ready !== 1'b0) $display("FAIL ignored_ready got %b exp 0", tx_ready); else pass_cnt++;
        spi_bits({8'hE1, 8'h00}, 8, 1'b1, got);
        total_cnt++; if (got[15:8] !== 8'h0F) $display("FAIL ignored_miso got %h exp 0f", got[15:8]); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'hE1) $display("FAIL ignored_rx_data got %h exp e1", rx_data); else pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        spi_bits({8'hAA, 8'h00}, 3, 1'b0, got);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (miso !== 1'b0) $display("FAIL midrst_miso got %b exp 0", miso); else pass_cnt++;
        total_cnt++; if (tx_ready !== 1'b1) $display("FAIL midrst_tx_ready got %b exp 1", tx_ready); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h00) $display("FAIL midrst_rx_data got %h exp 00", rx_data); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL midrst_rx_valid got %b exp 0", rx_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (underrun !== 1'b0) $display("FAIL midrst_underrun got %b exp 0", underrun); else pass_cnt++;
        cs = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        c0 = rx_cnt;
        spi_bits({8'h55, 8'h00}, 8, 1'b1, got);
        total_cnt++; if (rx_data !== 8'h55) $display("FAIL midrst_rx_after got %h exp 55", rx_data); else pass_cnt++;
        total_cnt++; if (rx_cnt !== c0 + 1) $display("FAIL midrst_pulses got %0d exp 1", rx_cnt - c0); else pass_cnt++;
        total_cnt++; if (got[15:8] !== 8'h00) $display("FAIL midrst_miso_after got %h exp 00", got[15:8]); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_underrun();
        test_partial();
        test_single();
        test_back_to_back();
        test_ignored_load();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
